// File: rtl/cci_mpf_csr_event_accum_pkg.sv
// ----------------------------------------------------------------------------
// cci_mpf_csrs_pkg
//
// Shared constants for the MPF CSR event accumulator.
// Holds the fixed event ordering on the events vector, the event count,
// and the index type used by the CSR read/clear path.
//
// Optional build macro used by the accumulator files: CCI_MPF_CSR_EVENT_SATURATE_EN
// ----------------------------------------------------------------------------
package cci_mpf_csrs_pkg;

    // Bit positions in the events vector (order is fixed by the shim wrapper).
    localparam int CCI_MPF_CSR_EVT_VTP_4KB_HIT      = 0;
    localparam int CCI_MPF_CSR_EVT_VTP_4KB_MISS     = 1;
    localparam int CCI_MPF_CSR_EVT_VTP_2MB_HIT      = 2;
    localparam int CCI_MPF_CSR_EVT_VTP_2MB_MISS     = 3;
    localparam int CCI_MPF_CSR_EVT_VTP_PT_WALK_BUSY = 4;
    localparam int CCI_MPF_CSR_EVT_VC_MAP_CHANGED   = 5;

    localparam int CCI_MPF_CSR_N_EVENTS       = 6;
    localparam int CCI_MPF_CSR_EVT_IDX_BITS   = 4;

    typedef logic [CCI_MPF_CSR_EVT_IDX_BITS-1:0] t_cci_mpf_csr_evt_idx;

endpackage

// File: rtl/cci_mpf_csr_event_accum_if.sv
// ----------------------------------------------------------------------------
// cci_mpf_csr_event_accum_if
//
// CSR-manager side bus of the event accumulator: counter read requests,
// counter clears and read responses.
//
// Handshake: there is no ready signal anywhere. rd_req_valid and clr_valid
// are single-cycle strobes that are always accepted in the cycle they are
// high; rd_rsp_valid is a single-cycle strobe the requester must consume.
// Responses return in request order, two cycles after the request cycle.
//
// Signals:
//   rd_req_valid / rd_req_idx / rd_req_tid : read request, index, MMIO tid
//   clr_valid / clr_mask                   : clear strobe, per-counter mask
//   rd_rsp_valid / rd_rsp_tid / rd_rsp_data: response strobe, echoed tid, data
//
// Modports: master = CSR manager (requester), slave = accumulator.
// Build macro affecting data contents: CCI_MPF_CSR_EVENT_SATURATE_EN
// ----------------------------------------------------------------------------
interface cci_mpf_csr_event_accum_if
    import cci_mpf_csrs_pkg::*;
#(
    parameter int N_EVENTS = CCI_MPF_CSR_N_EVENTS,
    parameter int IDX_BITS = CCI_MPF_CSR_EVT_IDX_BITS
);
    logic                rd_req_valid;
    logic [IDX_BITS-1:0] rd_req_idx;
    logic [8:0]          rd_req_tid;
    logic                clr_valid;
    logic [N_EVENTS-1:0] clr_mask;
    logic                rd_rsp_valid;
    logic [8:0]          rd_rsp_tid;
    logic [63:0]         rd_rsp_data;

    modport master (
        output rd_req_valid, rd_req_idx, rd_req_tid, clr_valid, clr_mask,
        input  rd_rsp_valid, rd_rsp_tid, rd_rsp_data
    );

    modport slave (
        input  rd_req_valid, rd_req_idx, rd_req_tid, clr_valid, clr_mask,
        output rd_rsp_valid, rd_rsp_tid, rd_rsp_data
    );
endinterface

// File: rtl/cci_mpf_csr_event_accum_ctr.sv
// ----------------------------------------------------------------------------
// cci_mpf_csr_event_ctr
//
// One event counter. Each edge: value <= (clr ? 0 : value) + inc, so a clear
// that coincides with an increment leaves the counter at 1 (no lost event).
//
// Default build: wraps modulo 2**CTR_BITS.
// With CCI_MPF_CSR_EVENT_SATURATE_EN: holds at all-ones; 'saturated' is a
// sticky flag set by an increment attempted at all-ones, cleared by clr/reset.
//
// Ports: clk, reset_n (sync, active low), inc, clr, value [, saturated]
// ----------------------------------------------------------------------------
module cci_mpf_csr_event_ctr #(
    parameter int CTR_BITS = 48
)(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                inc,
    input  logic                clr,
`ifdef CCI_MPF_CSR_EVENT_SATURATE_EN
    output logic                saturated,
`endif
    output logic [CTR_BITS-1:0] value
);
    // Value the increment applies to: the clear takes effect first.
    logic [CTR_BITS-1:0] base;
    assign base = clr ? '0 : value;

`ifdef CCI_MPF_CSR_EVENT_SATURATE_EN
    logic at_max;
    assign at_max = &base;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value     <= '0;
            saturated <= 1'b0;
        end else begin
            value     <= (inc && !at_max) ? base + 1'b1 : base;
            saturated <= (clr ? 1'b0 : saturated) | (inc & at_max);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            value <= '0;
        end else begin
            value <= base + CTR_BITS'(inc);
        end
    end
`endif

endmodule

// File: rtl/cci_mpf_csr_event_accum.sv
// ----------------------------------------------------------------------------
// cci_mpf_csr_event_accum
//
// Sums one-cycle event pulses from the MPF shims into per-event counters and
// serves indexed counter reads to the CSR manager's MMIO read path.
//
// Timing:
//   events -> ev_q (edge E) -> counter (edge E+1)
//   request captured at edge R, response registered at edge R+1 from the
//   counter values just before that edge (clears sampled at edge R visible).
//   Out-of-range indices return data 0 but still respond.
//
// Ports:
//   clk, reset_n (sync, active low)
//   events [N_EVENTS]  : one pulse per event per cycle
//   csr (slave modport): read request / clear / read response bus
//
// Build macro: CCI_MPF_CSR_EVENT_SATURATE_EN (saturating counters, bit 63 of
// rd_rsp_data = sticky saturated flag; CTR_BITS must then be <= 63).
// ----------------------------------------------------------------------------
module cci_mpf_csr_event_accum
    import cci_mpf_csrs_pkg::*;
#(
    parameter int N_EVENTS = CCI_MPF_CSR_N_EVENTS,
    parameter int CTR_BITS = 48,
    parameter int IDX_BITS = CCI_MPF_CSR_EVT_IDX_BITS
)(
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_EVENTS-1:0] events,
    cci_mpf_csr_event_accum_if.slave csr
);
    logic [N_EVENTS-1:0] ev_q;
    logic [CTR_BITS-1:0] ctr_val [N_EVENTS];
`ifdef CCI_MPF_CSR_EVENT_SATURATE_EN
    logic [N_EVENTS-1:0] ctr_sat;
`endif

    // Event stage: isolates the shim wires from the counter adders.
    always_ff @(posedge clk) begin
        if (!reset_n) ev_q <= '0;
        else          ev_q <= events;
    end

    for (genvar i = 0; i < N_EVENTS; i++) begin : g_ctr
        cci_mpf_csr_event_ctr #(.CTR_BITS(CTR_BITS)) u_ctr (
            .clk       (clk),
            .reset_n   (reset_n),
            .inc       (ev_q[i]),
            .clr       (csr.clr_valid & csr.clr_mask[i]),
`ifdef CCI_MPF_CSR_EVENT_SATURATE_EN
            .saturated (ctr_sat[i]),
`endif
            .value     (ctr_val[i])
        );
    end

    // Read stage 1: capture the request.
    logic                valid_q;
    logic [IDX_BITS-1:0] idx_q;
    logic [8:0]          tid_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            tid_q   <= '0;
        end else begin
            valid_q <= csr.rd_req_valid;
            if (csr.rd_req_valid) begin
                idx_q <= csr.rd_req_idx;
                tid_q <= csr.rd_req_tid;
            end
        end
    end

    // Index decode as a compare chain so indices >= N_EVENTS fall through to 0.
    logic [63:0] rd_sel;
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < N_EVENTS; i++) begin
            if (idx_q == IDX_BITS'(i)) begin
                rd_sel[CTR_BITS-1:0] = ctr_val[i];
`ifdef CCI_MPF_CSR_EVENT_SATURATE_EN
                rd_sel[63] = ctr_sat[i];
`endif
            end
        end
    end

    // Read stage 2: register the response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            csr.rd_rsp_valid <= 1'b0;
            csr.rd_rsp_tid   <= '0;
            csr.rd_rsp_data  <= '0;
        end else begin
            csr.rd_rsp_valid <= valid_q;
            csr.rd_rsp_tid   <= tid_q;
            csr.rd_rsp_data  <= rd_sel;
        end
    end

endmodule

// File: tb/tb_cci_mpf_csr_event_accum.sv
// ----------------------------------------------------------------------------
// tb_cci_mpf_csr_event_accum
//
// Directed bench for the event accumulator. Two instances: dut (48-bit
// counters) and dut4 (4-bit counters, for the wrap/saturate boundary).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_cci_mpf_csr_event_accum;
    import cci_mpf_csrs_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [5:0] ev;
    logic [5:0] ev4;

    cci_mpf_csr_event_accum_if #(.N_EVENTS(6), .IDX_BITS(4)) bus  ();
    cci_mpf_csr_event_accum_if #(.N_EVENTS(6), .IDX_BITS(4)) bus4 ();

    cci_mpf_csr_event_accum #(.N_EVENTS(6), .CTR_BITS(48), .IDX_BITS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .events  (ev),
        .csr     (bus.slave)
    );

    cci_mpf_csr_event_accum #(.N_EVENTS(6), .CTR_BITS(4), .IDX_BITS(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .events  (ev4),
        .csr     (bus4.slave)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int hi_edges;
    logic [63:0] exp_arr [4];

`ifdef CCI_MPF_CSR_EVENT_SATURATE_EN
    localparam logic [63:0] WRAP17_EXP = 64'h8000_0000_0000_000F;
`else
    localparam logic [63:0] WRAP17_EXP = 64'd1;
`endif

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic idle_req();
        bus.rd_req_valid  = 1'b0;
        bus4.rd_req_valid = 1'b0;
    endtask

    task automatic drive_req(input bit use4, input t_cci_mpf_csr_evt_idx idx, input logic [8:0] tid);
        if (use4) begin
            bus4.rd_req_valid = 1'b1;
            bus4.rd_req_idx   = idx;
            bus4.rd_req_tid   = tid;
        end else begin
            bus.rd_req_valid  = 1'b1;
            bus.rd_req_idx    = idx;
            bus.rd_req_tid    = tid;
        end
    endtask

    task automatic chk_rsp(input bit use4, input string tag, input logic [8:0] tid, input logic [63:0] data);
        if (use4) begin
            chk({tag, "_valid"}, 64'(bus4.rd_rsp_valid), 64'd1);
            chk({tag, "_tid"},   64'(bus4.rd_rsp_tid),   64'(tid));
            chk({tag, "_data"},  bus4.rd_rsp_data,       data);
        end else begin
            chk({tag, "_valid"}, 64'(bus.rd_rsp_valid),  64'd1);
            chk({tag, "_tid"},   64'(bus.rd_rsp_tid),    64'(tid));
            chk({tag, "_data"},  bus.rd_rsp_data,        data);
        end
    endtask

    // Single read: request cycle, capture edge, response edge, then check.
    task automatic read_chk(input bit use4, input t_cci_mpf_csr_evt_idx idx, input logic [8:0] tid,
                            input logic [63:0] data, input string tag);
        drive_req(use4, idx, tid);
        step();
        idle_req();
        step();
        chk_rsp(use4, tag, tid, data);
    endtask

    task automatic pulse_clear(input bit use4, input logic [5:0] mask);
        if (use4) begin bus4.clr_valid = 1'b1; bus4.clr_mask = mask; end
        else      begin bus.clr_valid  = 1'b1; bus.clr_mask  = mask; end
        step();
        bus.clr_valid  = 1'b0;
        bus4.clr_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n = 1'b0;
        ev  = '0;
        ev4 = '0;
        bus.rd_req_valid = 1'b0;  bus.rd_req_idx = '0;  bus.rd_req_tid = '0;
        bus.clr_valid    = 1'b0;  bus.clr_mask   = '0;
        bus4.rd_req_valid = 1'b0; bus4.rd_req_idx = '0; bus4.rd_req_tid = '0;
        bus4.clr_valid    = 1'b0; bus4.clr_mask   = '0;

        repeat (3) step();
        chk("rst_valid",  64'(bus.rd_rsp_valid),  64'd0);
        chk("rst_tid",    64'(bus.rd_rsp_tid),    64'd0);
        chk("rst_data",   bus.rd_rsp_data,        64'd0);
        chk("rst4_valid", 64'(bus4.rd_rsp_valid), 64'd0);
        reset_n = 1'b1;
        step();

        // Back-to-back reads of every counter after reset: all zero, tids echoed.
        for (int i = 0; i < 7; i++) begin
            if (i < 6) drive_req(1'b0, t_cci_mpf_csr_evt_idx'(i), 9'h1A5 + 9'(i));
            else       idle_req();
            step();
            if (i >= 1) chk_rsp(1'b0, "post_rst_read", 9'h1A5 + 9'(i - 1), 64'd0);
        end
        step();
        chk("rsp_valid_one_cycle", 64'(bus.rd_rsp_valid), 64'd0);

        // Ten pulses on 2mb_hit.
        ev[CCI_MPF_CSR_EVT_VTP_2MB_HIT] = 1'b1;
        repeat (10) step();
        ev = '0;
        repeat (3) step();
        read_chk(1'b0, t_cci_mpf_csr_evt_idx'(CCI_MPF_CSR_EVT_VTP_2MB_HIT),  9'h011, 64'd10, "evt2_ten");
        read_chk(1'b0, t_cci_mpf_csr_evt_idx'(CCI_MPF_CSR_EVT_VTP_2MB_MISS), 9'h012, 64'd0,  "evt3_zero");

        // 4kb_hit held high: a read sees every sample taken at edges before
        // the edge that captures the request; back-to-back reads step by 1.
        ev[CCI_MPF_CSR_EVT_VTP_4KB_HIT] = 1'b1;
        hi_edges = 0;
        repeat (5) begin step(); hi_edges++; end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                drive_req(1'b0, t_cci_mpf_csr_evt_idx'(CCI_MPF_CSR_EVT_VTP_4KB_HIT), 9'h040 + 9'(i));
                exp_arr[i] = 64'(hi_edges);
            end else begin
                idle_req();
            end
            step();
            hi_edges++;
            if (i >= 1) chk_rsp(1'b0, "held_ev0", 9'h040 + 9'(i - 1), exp_arr[i - 1]);
        end
        ev = '0;
        repeat (2) step();
        read_chk(1'b0, 4'd0, 9'h050, 64'd10, "held_ev0_total");

        // Clear coinciding with a pending increment: counter at 7 -> 1.
        step();
        pulse_clear(1'b0, 6'b000001);
        ev[CCI_MPF_CSR_EVT_VTP_4KB_HIT] = 1'b1;
        repeat (8) step();
        ev = '0;
        pulse_clear(1'b0, 6'b000001);
        read_chk(1'b0, 4'd0, 9'h060, 64'd1, "clear_plus_inc");
        read_chk(1'b0, 4'd2, 9'h061, 64'd10, "clear_masked_off");

        // Clear in the request cycle itself is visible in the snapshot.
        bus.clr_valid = 1'b1;
        bus.clr_mask  = 6'b000100;
        drive_req(1'b0, 4'd2, 9'h062);
        step();
        bus.clr_valid = 1'b0;
        idle_req();
        step();
        chk_rsp(1'b0, "clear_same_cycle", 9'h062, 64'd0);

        // Out-of-range indices still respond, with zero data.
        read_chk(1'b0, 4'd9,  9'h1FF, 64'd0, "oor_idx9");
        read_chk(1'b0, 4'd15, 9'h0F0, 64'd0, "oor_idx15");

        // 4-bit counter: 17 pulses wrap to 1 (or saturate at F with flag).
        ev4[CCI_MPF_CSR_EVT_VTP_4KB_MISS] = 1'b1;
        repeat (17) step();
        ev4 = '0;
        repeat (2) step();
        read_chk(1'b1, 4'd1, 9'h0AA, WRAP17_EXP, "ctr4_17_pulses");
        pulse_clear(1'b1, 6'b000010);
        read_chk(1'b1, 4'd1, 9'h0AB, 64'd0, "ctr4_after_clear");

        // Reset while a read is in flight: no response ever appears.
        ev[CCI_MPF_CSR_EVT_VTP_PT_WALK_BUSY] = 1'b1;
        ev[CCI_MPF_CSR_EVT_VC_MAP_CHANGED]   = 1'b1;
        repeat (3) step();
        ev = '0;
        drive_req(1'b0, 4'd0, 9'h123);
        step();
        idle_req();
        reset_n = 1'b0;
        step();
        chk("rst_inflight_0", 64'(bus.rd_rsp_valid), 64'd0);
        step();
        chk("rst_inflight_1", 64'(bus.rd_rsp_valid), 64'd0);
        reset_n = 1'b1;
        step();
        chk("rst_inflight_2", 64'(bus.rd_rsp_valid), 64'd0);

        for (int i = 0; i < 6; i++) begin
            read_chk(1'b0, t_cci_mpf_csr_evt_idx'(i), 9'h100 + 9'(i), 64'd0, "post_rst2");
        end
        read_chk(1'b1, 4'd1, 9'h0AC, 64'd0, "post_rst2_ctr4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
